// File: rtl/reservoir_pkg.sv
// rtl/reservoir_pkg.sv - shared widths, reader FSM states and FIFO depth for the reservoir history path
package reservoir_pkg;

   localparam int HIST_ADDR_WIDTH = 20;
   localparam int HIST_DATA_WIDTH = 32;
   localparam int FIFO_DEPTH      = 2;
   localparam int FIFO_CNT_W      = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      FINISH
   } reader_state_t;

endpackage

// File: rtl/history_skid_fifo.sv
// rtl/history_skid_fifo.sv - 2-entry synchronous FIFO absorbing the history memory read latency
module history_skid_fifo
   import reservoir_pkg::*;
#(
   parameter int WIDTH = HIST_DATA_WIDTH
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [WIDTH-1:0]      mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [FIFO_CNT_W-1:0] occ;
   logic                  pop_ok;

   assign pop_ok = pop & ~empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop_ok})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   assign empty = (occ == '0);
   assign full  = (occ == FIFO_CNT_W'(FIFO_DEPTH));
   assign head  = mem[rd_ptr];

endmodule

// File: rtl/reservoir_history_reader.sv
// rtl/reservoir_history_reader.sv - walks count history addresses and streams the words out
// Optional HISTORY_READER_STRIDE_EN adds a latched stride port; otherwise addresses advance by 1.
module reservoir_history_reader
   import reservoir_pkg::*;
#(
   parameter int ADDR_WIDTH = HIST_ADDR_WIDTH,
   parameter int DATA_WIDTH = HIST_DATA_WIDTH
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   count,
`ifdef HISTORY_READER_STRIDE_EN
   input  logic [ADDR_WIDTH-1:0] stride,
`endif
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_dout,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last
);

   localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH + 1)'(1);

   reader_state_t         state;
   logic                  inflight;
   logic [ADDR_WIDTH:0]   issue_rem;
   logic [ADDR_WIDTH:0]   out_rem;
   logic [ADDR_WIDTH-1:0] step;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [1:0]            occ;
   logic                  pop;
   logic                  issue;

   history_skid_fifo #(.WIDTH(DATA_WIDTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight),
      .push_data (mem_dout),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (m_data)
   );

   assign occ     = {fifo_full, ~fifo_full & ~fifo_empty};
   assign m_valid = ~fifo_empty;
   assign pop     = m_valid & m_ready;
   assign m_last  = m_valid && (out_rem == ONE);

   // Credit: the word for an issue this cycle lands in the FIFO next cycle, so it needs a free slot then.
   assign issue = (state == ISSUE) &&
                  (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

`ifdef HISTORY_READER_STRIDE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          step <= '0;
      else if (state == IDLE && start)  step <= stride;
   end
`else
   assign step = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         inflight  <= 1'b0;
         issue_rem <= '0;
         out_rem   <= '0;
         mem_addr  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         inflight <= issue;
         if (pop) out_rem <= out_rem - ONE;
         case (state)
            IDLE: if (start) begin
               mem_addr  <= base_addr;
               issue_rem <= count;
               out_rem   <= count;
               busy      <= 1'b1;
               state     <= (count == '0) ? FINISH : ISSUE;
            end
            ISSUE: if (issue) begin
               mem_addr  <= mem_addr + step;
               issue_rem <= issue_rem - ONE;
               if (issue_rem == ONE) state <= DRAIN;
            end
            // Handshake of the last word means the FIFO is empty and nothing is left in flight.
            DRAIN: if (pop && out_rem == ONE) begin
               done  <= 1'b1;
               state <= FINISH;
            end
            FINISH: if (done) begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end else begin
               done  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reservoir_history_reader.sv
// tb/tb_reservoir_history_reader.sv - randomized self-checking bench for reservoir_history_reader
module tb_reservoir_history_reader;
   import reservoir_pkg::*;

   localparam int AW = HIST_ADDR_WIDTH;
   localparam int DW = HIST_DATA_WIDTH;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   count;
`ifdef HISTORY_READER_STRIDE_EN
   logic [AW-1:0] stride;
`endif
   logic          busy;
   logic          done;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_dout;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic [11:0]   salt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Memory model: word at address a is {salt, a}; salt 0 gives mem[i] = i.
   always @(posedge clk) mem_dout <= {salt, mem_addr};

   reservoir_history_reader dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .count     (count),
`ifdef HISTORY_READER_STRIDE_EN
      .stride    (stride),
`endif
      .busy      (busy),
      .done      (done),
      .mem_addr  (mem_addr),
      .mem_dout  (mem_dout),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_last    (m_last)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},     busy,     0);
      check({tag, "_done"},     done,     0);
      check({tag, "_valid"},    m_valid,  0);
      check({tag, "_last"},     m_last,   0);
      check({tag, "_data"},     m_data,   0);
      check({tag, "_mem_addr"}, mem_addr, 0);
   endtask

   // mode 0: m_ready always 1 (exact cycle timing checked); 1: pattern 1,0,0 repeating; 2: random.
   task automatic run_cmd(input logic [AW-1:0] base, input int cnt, input logic [AW-1:0] strd,
                          input int mode, input bit ghost);
      logic [DW-1:0] exp_q[$];
      logic [DW-1:0] got_d[$];
      bit            got_l[$];
      logic [AW-1:0] a;
      logic [DW-1:0] data_prev;
      bit            stall_prev;
      bit            exp_v;
      int            cyc;
      int            done_cyc;
      int            budget;

      a = base;
      for (int k = 0; k < cnt; k++) begin
         exp_q.push_back({salt, a});
         a = a + strd;
      end
      stall_prev = 0;
      data_prev  = '0;
      done_cyc   = -1;
      budget     = 40 + 8 * cnt;

      start     = 1'b1;
      base_addr = base;
      count     = (AW + 1)'(cnt);
`ifdef HISTORY_READER_STRIDE_EN
      stride    = strd;
`endif
      m_ready   = (mode == 0);
      #1;
      check("idle_busy", busy, 0);

      for (cyc = 1; cyc < budget && done_cyc < 0; cyc++) begin
         next_cycle();
         start     = (ghost && cyc == 1) ? 1'b1 : ($urandom_range(0, 7) == 0);
         base_addr = AW'($urandom);
         count     = (AW + 1)'($urandom);
`ifdef HISTORY_READER_STRIDE_EN
         stride    = AW'($urandom);
`endif
         case (mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ((cyc - 1) % 3 == 0);
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
         #1;
         check("busy_during", busy, 1);
         if (stall_prev) begin
            check("stall_valid", m_valid, 1);
            check("stall_data", m_data, data_prev);
         end
         if (mode == 0) begin
            exp_v = (cyc >= 3 && cyc < 3 + cnt);
            check("valid_timing", m_valid, exp_v);
            if (exp_v) begin
               check("data_timing", m_data, exp_q[cyc-3]);
               check("last_timing", m_last, (cyc == 2 + cnt));
            end
            if (cyc == 1 && cnt > 0) check("first_addr", mem_addr, base);
         end
         if (m_valid && m_ready) begin
            got_d.push_back(m_data);
            got_l.push_back(m_last);
         end
         stall_prev = m_valid && !m_ready;
         data_prev  = m_data;
         if (done) done_cyc = cyc;
      end

      if (done_cyc < 0) check("done_timeout", 0, 1);
      else if (mode == 0) check("done_cycle", done_cyc, (cnt == 0) ? 2 : 3 + cnt);
      check("word_count", got_d.size(), cnt);
      for (int k = 0; k < cnt && k < got_d.size(); k++) begin
         check("word_data", got_d[k], exp_q[k]);
         check("word_last", got_l[k], (k == cnt - 1));
      end

      next_cycle();
      start   = 1'b0;
      m_ready = 1'b1;
      #1;
      check("post_busy",  busy,    0);
      check("post_done",  done,    0);
      check("post_valid", m_valid, 0);
   endtask

   initial begin
      logic [AW-1:0] strd;
      rst       = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      count     = '0;
      m_ready   = 1'b0;
      salt      = '0;
`ifdef HISTORY_READER_STRIDE_EN
      stride    = '0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      next_cycle();

      run_cmd(20'h00010, 4, 20'h1, 0, 0);
      run_cmd(20'h00010, 4, 20'h1, 1, 0);
      run_cmd(20'hFFFFE, 4, 20'h1, 0, 0);
      run_cmd(20'h00000, 0, 20'h1, 0, 1);
`ifdef HISTORY_READER_STRIDE_EN
      run_cmd(20'h00000, 3, 20'h3, 0, 0);
      run_cmd(20'h00040, 3, 20'h0, 0, 0);
`endif

      // Reset while stalled with two words buffered.
      salt      = 12'h001;
      start     = 1'b1;
      base_addr = 20'h00100;
      count     = (AW + 1)'(6);
`ifdef HISTORY_READER_STRIDE_EN
      stride    = 20'h1;
`endif
      m_ready   = 1'b0;
      repeat (6) begin
         next_cycle();
         start = 1'b0;
      end
      check("pre_rst_valid", m_valid, 1);
      check("pre_rst_data", m_data, {12'h001, 20'h00100});
      rst = 1'b1;
      #1;
      check_all_zero("mid_rst");
      next_cycle();
      next_cycle();
      rst     = 1'b0;
      m_ready = 1'b1;
      repeat (3) begin
         next_cycle();
         check("post_rst_valid", m_valid, 0);
         check("post_rst_busy",  busy,    0);
      end
      salt = 12'h002;
      run_cmd(20'h00200, 2, 20'h1, 0, 0);

      for (int i = 0; i < 12; i++) begin
         salt = 12'($urandom);
`ifdef HISTORY_READER_STRIDE_EN
         strd = AW'($urandom_range(0, 5));
`else
         strd = 20'h1;
`endif
         run_cmd(AW'($urandom), $urandom_range(0, 12), strd, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reservoir_history_reader.md
# reservoir_history_reader

Read-side sequencer for the reservoir history memory. On a start command it walks `count` consecutive history addresses from `base_addr`. It drives the memory's address port, absorbs the memory's fixed one-cycle registered read latency, and streams the words out on a valid/ready interface, with `m_last` marking the final word. It sits between the reservoir history memory and the output-layer (readout weight MAC) logic and sustains one word per cycle when the consumer does not stall.

## Interface
- `ADDR_WIDTH`, 20: history memory address width.
- `DATA_WIDTH`, 32: history word width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle command pulse; accepted only while `busy`=0.
- `base_addr` in ADDR_WIDTH: first address, sampled on an accepted `start`.
- `count` in ADDR_WIDTH+1: number of words to read, sampled on an accepted `start`; 0 is legal.
- `stride` in ADDR_WIDTH: address increment, sampled on an accepted `start`; present only with `HISTORY_READER_STRIDE_EN`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`, inclusive.
- `done` out 1: one-cycle pulse at completion.
- `mem_addr` out ADDR_WIDTH: registered address to the history memory read port.
- `mem_dout` in DATA_WIDTH: memory read data, valid the cycle after `mem_addr`.
- `m_valid` out 1: output word valid.
- `m_ready` in 1: consumer ready.
- `m_data` out DATA_WIDTH: output word.
- `m_last` out 1: qualifies the final word of a command.

## Operation
- FSM states:
  - IDLE: on `start`, latch `base_addr` and `count`, then go to ISSUE, or to FINISH if `count`=0.
  - ISSUE: issue one read per cycle while credit is available; after the last issue go to DRAIN.
  - DRAIN: wait until the FIFO is empty and nothing is in flight, then go to FINISH.
  - FINISH: assert `done` for one cycle, then go to IDLE.
- Buffering: a 2-entry output FIFO; `inflight` is a 1-bit flag marking an address issued last cycle.
- Issue rule: `occupancy + inflight − pop` < 2, where `pop` is `m_valid & m_ready` in the same cycle. This rule guarantees the FIFO never overflows and keeps full throughput.
- The word returning on `mem_dout` in the cycle after an issue is written to the FIFO unconditionally.
- Address arithmetic: next = addr + 1 (or + `stride`), modulo 2^ADDR_WIDTH; wrap-around is silent.
- Counters: the remaining-issue count and remaining-output count are ADDR_WIDTH+1 bits. `m_last` = (remaining-output == 1) on the FIFO head.
- `start` while `busy` is ignored, with no side effects.
- The memory address is not gated; the memory read port reads every cycle. Returns are tracked only through `inflight`.
- Reset, including mid-command:
  - Return to IDLE; FIFO emptied; `inflight` cleared.
  - `busy`, `done`, `m_valid`, `m_last` = 0.
  - `m_data` = 0, `mem_addr` = 0.
  - Data returning after reset is discarded.

## Timing
- `start` sampled at edge 0; `mem_addr` = `base_addr` in cycle 1; data on `mem_dout` in cycle 2; `m_valid` high in cycle 3.
- With `m_ready` held high, word k appears in cycle 3+k with no bubbles.
- `m_valid` and `m_data` stay stable until accepted.
- On deassertion of `m_ready`, at most 2 words are buffered and issue stalls within the same cycle.
- `done` pulses in the cycle after the handshake of the `m_last` word. For `count`=0, `done` pulses in cycle 2.
- A new `start` is accepted in the cycle after `done`, when `busy`=0.

## Configuration
- `HISTORY_READER_STRIDE_EN` defined: the `stride` port exists; the address advances by the latched stride. Stride 0 legally rereads the same address.
- Not defined: no `stride` port; the increment is the constant 1.

## Structure
- Shared package `reservoir_pkg` holds:
  - the `ADDR_WIDTH` and `DATA_WIDTH` defaults, shared with the history memory;
  - the FSM state typedef (IDLE, ISSUE, DRAIN, FINISH);
  - the FIFO depth constant, 2.
- One sub-module: `history_skid_fifo`, a 2-entry synchronous FIFO with push, pop, full, empty and head outputs, using the same async active-high `rst`.

## Test plan
- Memory preloaded with mem[i]=i; `base_addr`=0x10, `count`=4, `m_ready`=1 → `m_data` 0x10..0x13 in cycles 3–6; `m_last` only with 0x13; `done` in cycle 7.
- Same command with `m_ready` toggling 1,0,0,1,… → all 4 words in order, no loss or duplicates, `m_data` stable while stalled.
- `base_addr`=0xFFFFE, `count`=4 → addresses 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
- `count`=0 → no `m_valid`, `busy` high for one cycle, then `done` in cycle 2. A second `start` pulsed while `busy` is ignored.
- `rst` asserted during stall with 2 words buffered → all outputs 0 immediately; a later `start` with `count`=2 returns exactly 2 fresh words.
- With `HISTORY_READER_STRIDE_EN`: `base_addr`=0, `stride`=3, `count`=3 → words from addresses 0, 3, 6.
